// File: rtl/pipeline_hazard_ctrl_if.sv
// Pipeline hazard control bus: decode/writeback/branch/memory status in, stage controls out.
//   master : pipeline side, drives hazard sources and consumes stage controls
//   slave  : hazard controller, consumes hazard sources and drives stage controls
interface pipeline_hazard_ctrl_if;
    logic [4:0] id_rs_addr;
    logic [4:0] id_rt_addr;
    logic       id_uses_rs;
    logic       id_uses_rt;
    logic       ex_shouldWriteRegister;
    logic [4:0] ex_registerWriteAddress;
    logic       mem_shouldWriteRegister;
    logic [4:0] mem_registerWriteAddress;
    logic       id_shouldJumpOrBranch;
    logic       mem_access;
    logic       MIO_ready;

    logic       pc_en;
    logic       if_id_en;
    logic       if_id_flush;
    logic       id_ex_en;
    logic       id_ex_bubble;
    logic       ex_mem_en;
    logic       mem_wb_bubble;
    logic       raw_stall;

    modport master (
        output id_rs_addr, id_rt_addr, id_uses_rs, id_uses_rt,
               ex_shouldWriteRegister, ex_registerWriteAddress,
               mem_shouldWriteRegister, mem_registerWriteAddress,
               id_shouldJumpOrBranch, mem_access, MIO_ready,
        input  pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_bubble,
               ex_mem_en, mem_wb_bubble, raw_stall
    );

    modport slave (
        input  id_rs_addr, id_rt_addr, id_uses_rs, id_uses_rt,
               ex_shouldWriteRegister, ex_registerWriteAddress,
               mem_shouldWriteRegister, mem_registerWriteAddress,
               id_shouldJumpOrBranch, mem_access, MIO_ready,
        output pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_bubble,
               ex_mem_en, mem_wb_bubble, raw_stall
    );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// Central stall/flush sequencer for the 5-stage pipeline.
// Stage controls are combinational from current state and inputs; the memory-wait
// FSM, sticky timeout flag and saturating performance counters update on clk.
//   clk, rst       : clock, synchronous active-high reset
//   bus (slave)    : hazard sources in, stage enables/bubbles/flush and raw_stall out
//   fsm_state      : 00 RUN, 01 MEM_WAIT, 10 ERROR
//   mem_timeout    : sticky, set on entry to ERROR
//   stall_count    : RAW bubble cycles
//   memwait_count  : memory freeze cycles (ERROR excluded)
//   flush_count    : IF/ID flushes issued
module pipeline_hazard_ctrl #(
    parameter int unsigned MEM_TIMEOUT = 255,
    parameter int unsigned CNT_W       = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    pipeline_hazard_ctrl_if.slave bus,
    output logic [1:0]           fsm_state,
    output logic                 mem_timeout,
    output logic [CNT_W-1:0]     stall_count,
    output logic [CNT_W-1:0]     memwait_count,
    output logic [CNT_W-1:0]     flush_count
);

    localparam int unsigned WAIT_W = 16;
    localparam logic [WAIT_W-1:0] WAIT_LIMIT = WAIT_W'(MEM_TIMEOUT);
    localparam logic [CNT_W-1:0]  CNT_MAX    = '1;

    typedef enum logic [1:0] {
        stRun     = 2'b00,
        stMemWait = 2'b01,
        stError   = 2'b10
    } state_t;

    state_t            state;
    logic [WAIT_W-1:0] waitCnt;
    logic              hazard;
    logic              freeze;
    logic              rawStall;
    logic              ifIdFlush;

    // RAW check for one source operand against EX and MEM writers; $0 never hazards.
    function automatic logic srcHazard(input logic uses, input logic [4:0] addr);
        return uses && (addr != 5'd0) &&
               ((bus.ex_shouldWriteRegister  && (bus.ex_registerWriteAddress  == addr)) ||
                (bus.mem_shouldWriteRegister && (bus.mem_registerWriteAddress == addr)));
    endfunction

    assign hazard = srcHazard(bus.id_uses_rs, bus.id_rs_addr) ||
                    srcHazard(bus.id_uses_rt, bus.id_rt_addr);

    assign freeze = ((state == stRun) && bus.mem_access && !bus.MIO_ready) ||
                    ((state == stMemWait) && !bus.MIO_ready) ||
                    (state == stError);

    // Stage control priority: reset, freeze, RAW hazard (branch deferred), branch flush, run.
    always_comb begin
        bus.pc_en         = 1'b0;
        bus.if_id_en      = 1'b0;
        bus.id_ex_en      = 1'b0;
        bus.id_ex_bubble  = 1'b0;
        bus.ex_mem_en     = 1'b0;
        bus.mem_wb_bubble = 1'b0;
        rawStall          = 1'b0;
        ifIdFlush         = 1'b0;
        if (rst) begin
            // everything held low
        end else if (freeze) begin
            bus.mem_wb_bubble = 1'b1;
        end else if (hazard) begin
            rawStall         = 1'b1;
            bus.id_ex_bubble = 1'b1;
            bus.id_ex_en     = 1'b1;
            bus.ex_mem_en    = 1'b1;
        end else begin
            bus.pc_en     = 1'b1;
            bus.if_id_en  = 1'b1;
            bus.id_ex_en  = 1'b1;
            bus.ex_mem_en = 1'b1;
            ifIdFlush     = bus.id_shouldJumpOrBranch;
        end
    end

    assign bus.raw_stall   = rawStall;
    assign bus.if_id_flush = ifIdFlush;
    assign fsm_state       = state;

    // Memory-wait FSM, timeout flag and saturating counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= stRun;
            waitCnt       <= '0;
            mem_timeout   <= 1'b0;
            stall_count   <= '0;
            memwait_count <= '0;
            flush_count   <= '0;
        end else begin
            case (state)
                stRun: begin
                    if (bus.mem_access && !bus.MIO_ready) begin
                        state   <= stMemWait;
                        waitCnt <= WAIT_W'(1);
                    end
                end
                stMemWait: begin
                    // a late MIO_ready beats the timeout in the same cycle
                    if (bus.MIO_ready) begin
                        state   <= stRun;
                        waitCnt <= '0;
                    end else if (waitCnt == WAIT_LIMIT) begin
                        state       <= stError;
                        mem_timeout <= 1'b1;
                    end else begin
                        waitCnt <= waitCnt + WAIT_W'(1);
                    end
                end
                stError: begin
                    mem_timeout <= 1'b1;
                end
                default: begin
                    state   <= stRun;
                    waitCnt <= '0;
                end
            endcase

            if (rawStall && (stall_count != CNT_MAX))
                stall_count <= stall_count + CNT_W'(1);
            if (freeze && (state != stError) && (memwait_count != CNT_MAX))
                memwait_count <= memwait_count + CNT_W'(1);
            if (ifIdFlush && (flush_count != CNT_MAX))
                flush_count <= flush_count + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed-vector bench for pipeline_hazard_ctrl with a scoreboard queue.
// Each step drives one cycle of inputs and pushes the hand-computed control word
// for that cycle plus the registered status expected at the start of that cycle.
module tb_pipeline_hazard_ctrl;

    localparam int unsigned CNT_W = 2;

    // control word: {pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_bubble, ex_mem_en, mem_wb_bubble, raw_stall}
    localparam logic [7:0] NRM = 8'b1101_0100;
    localparam logic [7:0] HAZ = 8'b0001_1101;
    localparam logic [7:0] BRF = 8'b1111_0100;
    localparam logic [7:0] FRZ = 8'b0000_0010;
    localparam logic [7:0] ZER = 8'b0000_0000;

    typedef struct {
        int         id;
        logic [7:0] ctl;
        logic [1:0] st;
        logic       to;
        logic [1:0] sc;
        logic [1:0] mc;
        logic [1:0] fc;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst;
    logic [1:0]       fsm_state;
    logic             mem_timeout;
    logic [CNT_W-1:0] stall_count;
    logic [CNT_W-1:0] memwait_count;
    logic [CNT_W-1:0] flush_count;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;
    int   stepId = 0;

    pipeline_hazard_ctrl_if bus();

    pipeline_hazard_ctrl #(.MEM_TIMEOUT(4), .CNT_W(CNT_W)) dut (
        .clk           (clk),
        .rst           (rst),
        .bus           (bus.slave),
        .fsm_state     (fsm_state),
        .mem_timeout   (mem_timeout),
        .stall_count   (stall_count),
        .memwait_count (memwait_count),
        .flush_count   (flush_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input int id, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s step %0d: got %0h expected %0h", nm, id, act, exp);
        end
    endtask

    // Monitor: the DUT presents controls every cycle; compare mid-cycle.
    always @(negedge clk) begin
        if (q.size() > 0) begin
            exp_t e;
            logic [7:0] ctl;
            e   = q.pop_front();
            ctl = {bus.pc_en, bus.if_id_en, bus.if_id_flush, bus.id_ex_en,
                   bus.id_ex_bubble, bus.ex_mem_en, bus.mem_wb_bubble, bus.raw_stall};
            chk("ctl",           e.id, 32'(ctl),           32'(e.ctl));
            chk("fsm_state",     e.id, 32'(fsm_state),     32'(e.st));
            chk("mem_timeout",   e.id, 32'(mem_timeout),   32'(e.to));
            chk("stall_count",   e.id, 32'(stall_count),   32'(e.sc));
            chk("memwait_count", e.id, 32'(memwait_count), 32'(e.mc));
            chk("flush_count",   e.id, 32'(flush_count),   32'(e.fc));
        end
    end

    task automatic step(
        input logic r,
        input logic urs, input logic [4:0] rs, input logic urt, input logic [4:0] rt,
        input logic exw, input logic [4:0] exa, input logic mw, input logic [4:0] ma,
        input logic br, input logic macc, input logic rdy,
        input logic [7:0] ctl, input logic [1:0] st, input logic to,
        input logic [1:0] sc, input logic [1:0] mc, input logic [1:0] fc);
        exp_t e;
        @(posedge clk);
        #1;
        rst                          = r;
        bus.id_uses_rs               = urs;
        bus.id_rs_addr               = rs;
        bus.id_uses_rt               = urt;
        bus.id_rt_addr               = rt;
        bus.ex_shouldWriteRegister   = exw;
        bus.ex_registerWriteAddress  = exa;
        bus.mem_shouldWriteRegister  = mw;
        bus.mem_registerWriteAddress = ma;
        bus.id_shouldJumpOrBranch    = br;
        bus.mem_access               = macc;
        bus.MIO_ready                = rdy;
        stepId++;
        e.id = stepId; e.ctl = ctl; e.st = st; e.to = to;
        e.sc = sc; e.mc = mc; e.fc = fc;
        q.push_back(e);
    endtask

    initial begin
        rst = 1'b1;
        bus.id_uses_rs = 0; bus.id_rs_addr = 0; bus.id_uses_rt = 0; bus.id_rt_addr = 0;
        bus.ex_shouldWriteRegister = 0; bus.ex_registerWriteAddress = 0;
        bus.mem_shouldWriteRegister = 0; bus.mem_registerWriteAddress = 0;
        bus.id_shouldJumpOrBranch = 0; bus.mem_access = 0; bus.MIO_ready = 0;
        repeat (2) @(posedge clk);

        //   r urs rs urt rt exw exa mw ma br acc rdy  ctl  st to sc mc fc
        // reset holds every control low despite hazard/branch/freeze inputs
        step(1, 1, 5, 0, 0, 1, 5, 0, 0, 1, 1, 0, ZER, 0, 0, 0, 0, 0);
        // RAW on rs from EX, then a different EX destination
        step(0, 1, 5, 0, 0, 1, 5, 0, 0, 0, 0, 1, HAZ, 0, 0, 0, 0, 0);
        step(0, 1, 5, 0, 0, 1, 6, 0, 0, 0, 0, 1, NRM, 0, 0, 1, 0, 0);
        // $0 never hazards
        step(0, 1, 0, 0, 0, 1, 0, 0, 0, 0, 0, 1, NRM, 0, 0, 1, 0, 0);
        // RAW on rt from MEM; same match ignored when rt unused
        step(0, 0, 0, 1, 7, 0, 0, 1, 7, 0, 0, 1, HAZ, 0, 0, 1, 0, 0);
        step(0, 0, 0, 0, 7, 0, 0, 1, 7, 0, 0, 1, NRM, 0, 0, 2, 0, 0);
        // taken branch flushes exactly one cycle
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1, BRF, 0, 0, 2, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, NRM, 0, 0, 2, 0, 1);
        // memory wait: three not-ready cycles then release
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, FRZ, 0, 0, 2, 0, 1);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, FRZ, 1, 0, 2, 1, 1);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, FRZ, 1, 0, 2, 2, 1);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, NRM, 1, 0, 2, 3, 1);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, NRM, 0, 0, 2, 3, 1);
        // hazard + branch + freeze, release with hazard, then branch alone
        step(0, 1, 5, 0, 0, 1, 5, 0, 0, 1, 1, 0, FRZ, 0, 0, 2, 3, 1);
        step(0, 1, 5, 0, 0, 1, 5, 0, 0, 1, 1, 1, HAZ, 1, 0, 2, 3, 1);
        step(0, 1, 5, 0, 0, 0, 5, 0, 0, 1, 0, 1, BRF, 0, 0, 3, 3, 1);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, NRM, 0, 0, 3, 3, 2);
        // reset, then five hazard cycles saturate the 2-bit stall counter
        step(1, 1, 5, 0, 0, 1, 5, 0, 0, 0, 0, 1, ZER, 0, 0, 3, 3, 2);
        for (int i = 0; i < 5; i++) begin
            logic [1:0] sc;
            sc = (i > 3) ? 2'd3 : 2'(i);
            step(0, 1, 9, 0, 0, 1, 9, 0, 0, 0, 0, 1, HAZ, 0, 0, sc, 0, 0);
        end
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, NRM, 0, 0, 3, 0, 0);
        // timeout: ready held low, ERROR after the fifth frozen cycle
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, FRZ, 0, 0, 3, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, FRZ, 1, 0, 3, 1, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, FRZ, 1, 0, 3, 2, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, FRZ, 1, 0, 3, 3, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, FRZ, 1, 0, 3, 3, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1, FRZ, 2, 1, 3, 3, 0);
        step(0, 1, 5, 0, 0, 1, 5, 0, 0, 0, 0, 1, FRZ, 2, 1, 3, 3, 0);
        step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, ZER, 2, 1, 3, 3, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, NRM, 0, 0, 0, 0, 0);
        // ready arrives on the same cycle the limit is reached: back to RUN
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, FRZ, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, FRZ, 1, 0, 0, 1, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, FRZ, 1, 0, 0, 2, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, FRZ, 1, 0, 0, 3, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, NRM, 1, 0, 0, 3, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, NRM, 0, 0, 0, 3, 0);
        // reset in MEM_WAIT with ready still low
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, FRZ, 0, 0, 0, 3, 0);
        step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, ZER, 1, 0, 0, 3, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, NRM, 0, 0, 0, 0, 0);

        for (int i = 0; i < 10 && q.size() > 0; i++) @(posedge clk);
        if (q.size() > 0) begin
            errors++;
            $display("FAIL drain: %0d entries left, expected 0", q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
